// File: rtl/decoder_scan_seq_if.sv
// Control/status bundle between a scan controller and decoder_scan_seq.
// The slave side is the sequencer; the master side is whoever requests scans.
interface decoder_scan_seq_if #(
   parameter int unsigned DWELL_W = 8
);
   logic               start;
   logic               stop;
   logic               mode;
   logic [5:0]         first;
   logic [5:0]         last;
   logic [DWELL_W-1:0] dwell;
   logic               en;
   logic [5:0]         A;
   logic               busy;
   logic               done;
   logic               wrap;

   modport master (
      output start, stop, mode, first, last, dwell,
      input  en, A, busy, done, wrap
   );

   modport slave (
      input  start, stop, mode, first, last, dwell,
      output en, A, busy, done, wrap
   );
endinterface

// File: rtl/decoder_scan_seq.sv
// Address scan sequencer feeding a 6-to-64 decoder: steps A through a wrap-capable range,
// holding each address dwell+1 cycles, single-pass or continuous.
module decoder_scan_seq #(
   parameter int unsigned DWELL_W = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   decoder_scan_seq_if.slave    bus
);

   localparam logic [0:0] StIdle   = 1'b0;
   localparam logic [0:0] StActive = 1'b1;

   logic [0:0]         state_q, state_d;
   logic               en_q, en_d;
   logic [5:0]         a_q, a_d;
   logic               done_q, done_d;
   logic               wrap_q, wrap_d;
   logic               mode_q, mode_d;
   logic [5:0]         first_q, first_d;
   logic [5:0]         last_q, last_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      a_d     = a_q;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
      mode_d  = mode_q;
      first_d = first_q;
      last_d  = last_q;
      dwell_d = dwell_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         StIdle: begin
            en_d = 1'b0;
            // stop in IDLE vetoes a simultaneous start
            if (bus.start && !bus.stop) begin
               mode_d  = bus.mode;
               first_d = bus.first;
               last_d  = bus.last;
               dwell_d = bus.dwell;
               a_d     = bus.first;
               cnt_d   = bus.dwell;
               en_d    = 1'b1;
               state_d = StActive;
            end
         end
         StActive: begin
            if (bus.stop) begin
               en_d    = 1'b0;
               state_d = StIdle;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (a_q != last_q) begin
               // 6-bit add wraps 63 -> 0 for ranges with first > last
               a_d   = a_q + 6'd1;
               cnt_d = dwell_q;
            end else if (mode_q) begin
               a_d    = first_q;
               cnt_d  = dwell_q;
               wrap_d = 1'b1;
            end else begin
               en_d    = 1'b0;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: begin
            en_d    = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         en_q    <= 1'b0;
         a_q     <= 6'd0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
         mode_q  <= 1'b0;
         first_q <= 6'd0;
         last_q  <= 6'd0;
         dwell_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         a_q     <= a_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
         mode_q  <= mode_d;
         first_q <= first_d;
         last_q  <= last_d;
         dwell_q <= dwell_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.en   = en_q;
   assign bus.A    = a_q;
   assign bus.busy = (state_q == StActive);
   assign bus.done = done_q;
   assign bus.wrap = wrap_q;

   // Pulses are exclusive, and en tracks the ACTIVE state exactly.
   a_pulse_excl: assert property (@(posedge clk) disable iff (!rst_n) !(done_q && wrap_q));
   a_en_busy: assert property (@(posedge clk) disable iff (!rst_n)
                               en_q == (state_q == StActive));

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Scoreboard bench for decoder_scan_seq: an address-range model queues expected per-cycle
// outputs when a scan is launched; each scenario pops and compares on the falling edge.
module tb_decoder_scan_seq;

   typedef struct packed {
      logic       en;
      logic [5:0] a;
      logic       busy;
      logic       done;
      logic       wrap;
   } obs_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   last_a;
   obs_t exp_q[$];
   obs_t got;
   obs_t e;

   decoder_scan_seq_if #(.DWELL_W(8)) bus ();

   decoder_scan_seq #(.DWELL_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic string fmt(input obs_t o);
      return $sformatf("en=%0b A=%0d busy=%0b done=%0b wrap=%0b", o.en, o.a, o.busy, o.done,
                       o.wrap);
   endfunction

   function automatic obs_t mk(input logic en, input int a, input logic busy, input logic done,
                               input logic wrap);
      obs_t r;
      r.en   = en;
      r.a    = 6'(a);
      r.busy = busy;
      r.done = done;
      r.wrap = wrap;
      return r;
   endfunction

   // Enumerate addresses of the range directly; first cycle of a reloaded pass carries wrap.
   task automatic push_pass(input int f, input int l, input int d, input bit m, input int passes);
      int k;
      k = ((l - f) & 63) + 1;
      for (int p = 0; p < passes; p++)
         for (int i = 0; i < k; i++)
            for (int j = 0; j <= d; j++)
               exp_q.push_back(mk(1'b1, (f + i) & 63, 1'b1, 1'b0, (m && p > 0 && i == 0 && j == 0)));
      if (!m) exp_q.push_back(mk(1'b0, l, 1'b0, 1'b1, 1'b0));
      last_a = l;
   endtask

   task automatic start_scan(input int f, input int l, input int d, input bit m);
      @(negedge clk);
      bus.first = 6'(f);
      bus.last  = 6'(l);
      bus.dwell = 8'(d);
      bus.mode  = m;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      got = {bus.en, bus.A, bus.busy, bus.done, bus.wrap};
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL reset_initial: got %s, expected all zero", fmt(got));
      end
      @(negedge clk) rst_n = 1'b1;
      start_scan(0, 63, 0, 1'b0);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      got = {bus.en, bus.A, bus.busy, bus.done, bus.wrap};
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL reset_async: got %s, expected all zero", fmt(got));
      end
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         got = {bus.en, bus.A, bus.busy, bus.done, bus.wrap};
         checks++;
         if (got !== '0) begin
            errors++;
            $display("FAIL reset_idle[%0d]: got %s, expected all zero", i, fmt(got));
         end
      end
      last_a = 0;
   endtask

   task automatic test_single_pass();
      start_scan(3, 6, 0, 1'b0);
      push_pass(3, 6, 0, 1'b0, 1);
      for (int i = 0; exp_q.size() != 0; i++) begin
         @(negedge clk);
         e   = exp_q.pop_front();
         got = {bus.en, bus.A, bus.busy, bus.done, bus.wrap};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL single_pass[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
         end
      end
   endtask

   task automatic test_dwell_wrap();
      start_scan(62, 1, 2, 1'b0);
      push_pass(62, 1, 2, 1'b0, 1);
      for (int i = 0; exp_q.size() != 0; i++) begin
         @(negedge clk);
         e   = exp_q.pop_front();
         got = {bus.en, bus.A, bus.busy, bus.done, bus.wrap};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL dwell_wrap[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
         end
      end
   endtask

   task automatic test_continuous();
      start_scan(10, 11, 0, 1'b1);
      push_pass(10, 11, 0, 1'b1, 3);
      for (int i = 0; exp_q.size() != 0; i++) begin
         @(negedge clk);
         e   = exp_q.pop_front();
         got = {bus.en, bus.A, bus.busy, bus.done, bus.wrap};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL continuous[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
         end
      end
      bus.stop = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, 11, 1'b0, 1'b0, 1'b0));
      for (int i = 0; exp_q.size() != 0; i++) begin
         @(negedge clk);
         e   = exp_q.pop_front();
         got = {bus.en, bus.A, bus.busy, bus.done, bus.wrap};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL cont_stop[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
         end
      end
      bus.stop = 1'b0;
      last_a = 11;
   endtask

   task automatic test_corner();
      // start+stop together in IDLE: nothing happens
      @(negedge clk);
      bus.first = 6'd20;
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, last_a, 1'b0, 1'b0, 1'b0));
      for (int i = 0; exp_q.size() != 0; i++) begin
         @(negedge clk);
         e   = exp_q.pop_front();
         got = {bus.en, bus.A, bus.busy, bus.done, bus.wrap};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL start_stop_idle[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
         end
      end
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      // start and config changes while ACTIVE are ignored
      start_scan(3, 6, 1, 1'b0);
      push_pass(3, 6, 1, 1'b0, 1);
      for (int i = 0; exp_q.size() != 0; i++) begin
         @(negedge clk);
         e   = exp_q.pop_front();
         got = {bus.en, bus.A, bus.busy, bus.done, bus.wrap};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL start_ignored[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
         end
         if (i == 2) begin
            bus.start = 1'b1;
            bus.first = 6'd40;
            bus.last  = 6'd50;
            bus.dwell = 8'd0;
            bus.mode  = 1'b1;
         end
         if (i == 4) bus.start = 1'b0;
      end
      // one-address range at the top of the space
      start_scan(63, 63, 5, 1'b0);
      push_pass(63, 63, 5, 1'b0, 1);
      for (int i = 0; exp_q.size() != 0; i++) begin
         @(negedge clk);
         e   = exp_q.pop_front();
         got = {bus.en, bus.A, bus.busy, bus.done, bus.wrap};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL single_addr[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
         end
      end
   endtask

   task automatic test_full_range();
      int hits[64];
      logic [63:0] onehot;
      for (int i = 0; i < 64; i++) hits[i] = 0;
      start_scan(0, 63, 0, 1'b0);
      push_pass(0, 63, 0, 1'b0, 1);
      for (int i = 0; exp_q.size() != 0; i++) begin
         @(negedge clk);
         e   = exp_q.pop_front();
         got = {bus.en, bus.A, bus.busy, bus.done, bus.wrap};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL full_range[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
         end
         onehot = bus.en ? (64'd1 << bus.A) : 64'd0;
         for (int b = 0; b < 64; b++) if (onehot[b]) hits[b]++;
      end
      for (int b = 0; b < 64; b++) begin
         checks++;
         if (hits[b] != 1) begin
            errors++;
            $display("FAIL decoder_hit[%0d]: got %0d selections, expected 1", b, hits[b]);
         end
      end
   endtask

   task automatic test_back_to_back();
      start_scan(3, 4, 0, 1'b0);
      push_pass(3, 4, 0, 1'b0, 1);
      for (int i = 0; exp_q.size() != 0; i++) begin
         @(negedge clk);
         e   = exp_q.pop_front();
         got = {bus.en, bus.A, bus.busy, bus.done, bus.wrap};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL b2b_first[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
         end
      end
      // restart sampled during the done cycle
      bus.first = 6'd20;
      bus.last  = 6'd21;
      bus.dwell = 8'd1;
      bus.mode  = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      push_pass(20, 21, 1, 1'b0, 1);
      for (int i = 0; exp_q.size() != 0; i++) begin
         @(negedge clk);
         e   = exp_q.pop_front();
         got = {bus.en, bus.A, bus.busy, bus.done, bus.wrap};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL b2b_second[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
         end
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      last_a    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.mode  = 1'b0;
      bus.first = 6'd0;
      bus.last  = 6'd0;
      bus.dwell = 8'd0;
      test_reset();
      test_single_pass();
      test_dwell_wrap();
      test_continuous();
      test_corner();
      test_full_range();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit, got no finish, expected finish");
      $fatal(1);
   end

endmodule
